suprloco_rom_fetch: RTL and testbench
=====================================

Name: suprloco_rom_fetch

Overview:
- Program-ROM fetch bridge between the main Z80 bus and the SDRAM-backed ROM port.
- Sits directly upstream of the main CPU/decrypter stage. Supplies the raw, still-encrypted ROM byte and the WAIT_n line to that stage.
- Stretches CPU memory-read cycles with WAIT_n until the memory port acknowledges.
- Keeps a one-entry last-address cache so repeated reads of the same address complete with no wait.

Parameters:
- ROM_TOP, 16'hBFFF, highest CPU address decoded as program ROM.
- TIMEOUT, 255, i_CLK cycles allowed between request and acknowledge before a forced release (range 1..255).

Ports:
- i_CLK  input  1  system clock; the only clock.
- i_RST  input  1  reset, synchronous, active-high.
- i_ADDR  input  16  CPU address bus.
- i_MREQ_n  input  1  CPU memory request.
- i_RD_n  input  1  CPU read strobe.
- i_RFSH_n  input  1  CPU refresh indicator.
- o_WAIT_n  output  1  wait line to the CPU.
- o_DO  output  8  raw ROM byte to the CPU data mux/decrypter.
- o_ROM_RQ  output  1  memory-port request, level.
- o_ROM_ADDR  output  16  memory-port byte address.
- i_ROM_ACK  input  1  memory-port acknowledge, 1-cycle pulse.
- i_ROM_DATA  input  8  memory-port data, valid with i_ROM_ACK.
- o_TIMEOUT  output  1  sticky flag: a fetch timed out.

Behaviour:
- Reset (i_RST=1 at a clock edge):
  - State IDLE; o_WAIT_n=1; o_ROM_RQ=0; o_ROM_ADDR=0; o_DO=8'hFF; o_TIMEOUT=0.
  - Cache valid=0, tag=0; timeout counter=0.
- ROM read qualifier:
  - rd_cyc = ~i_MREQ_n & ~i_RD_n & i_RFSH_n & (i_ADDR <= ROM_TOP).
  - Writes, refresh cycles, IO cycles and addresses above ROM_TOP never start a fetch. o_WAIT_n stays 1 for them.
- State IDLE:
  - On rd_cyc with cache valid and tag==i_ADDR (hit): o_DO already holds the byte; o_WAIT_n stays 1; go HOLD.
  - On rd_cyc with a miss: next edge o_WAIT_n=0, o_ROM_RQ=1, o_ROM_ADDR=i_ADDR, counter=0; go REQ. WAIT_n latency is 1 i_CLK from the qualifier.
  - i_ROM_ACK in IDLE or HOLD is ignored.
- State REQ:
  - o_ROM_RQ and o_ROM_ADDR stay stable until acknowledge.
  - On i_ROM_ACK: o_DO=i_ROM_DATA; cache tag=o_ROM_ADDR; valid=1; o_ROM_RQ=0; o_WAIT_n=1; go HOLD. An ack is honoured only while o_ROM_RQ=1.
  - Without ack: counter increments each cycle.
  - When counter reaches TIMEOUT with no ack: o_DO=8'hFF; valid=0; o_ROM_RQ=0; o_WAIT_n=1; o_TIMEOUT=1 (sticky until reset); go HOLD.
  - Ack and timeout in the same cycle: ack wins; o_TIMEOUT is not set.
  - i_MREQ_n rising while in REQ: the fetch still completes and fills the cache, then go HOLD.
- State HOLD:
  - Stays until i_MREQ_n=1, then IDLE. This guarantees one fetch per bus cycle.
- o_DO holds its last value between fetches.
- Address compare is full 16-bit. No partial match.
- Reset during REQ or HOLD aborts immediately to reset values. A late ack arriving after reset is ignored (IDLE).

Test Plan:
1. Reset, then read 16'h0123; memory acks 5 cycles after o_ROM_RQ with 8'h5A. Required: o_WAIT_n low 1 cycle after qualifier; o_ROM_ADDR=16'h0123; o_WAIT_n back to 1 and o_DO=8'h5A on the ack edge; exactly one request.
2. End that cycle (MREQ_n high), then read 16'h0123 again. Required: no o_ROM_RQ, o_WAIT_n never low, o_DO=8'h5A. Then read 16'h0124: new request issued.
3. Read 16'hC000, write to 16'h0010, and a refresh cycle at 16'h0010. Required: o_ROM_RQ stays 0 and o_WAIT_n stays 1 throughout.
4. TIMEOUT=8, read 16'h2000 with no ack. Required: o_WAIT_n released after 8 cycles in REQ; o_DO=8'hFF; o_TIMEOUT=1. Re-read 16'h2000 misses and issues a new request.
5. Assert i_RST while in REQ, then pulse i_ROM_ACK. Required: outputs at reset values, ack ignored, cache invalid; next read of the same address issues a fresh request.

Source files
------------

// File: rtl/suprloco_rom_fetch.sv
// -----------------------------------------------------------------------------
// suprloco_rom_fetch
//
// Program-ROM fetch bridge between the main Z80 bus and the SDRAM-backed ROM
// port. It feeds the raw, still-encrypted ROM byte and the WAIT_n line to the
// CPU/decrypter stage that sits directly downstream.
//
// Each qualified CPU memory read of program ROM either hits a one-entry
// last-address cache and completes with no wait, or is stretched with WAIT_n
// while a request goes out to the memory port. If the port does not
// acknowledge within TIMEOUT cycles, the CPU is released with 8'hFF and a
// sticky timeout flag is raised.
//
// Parameters:
//   ROM_TOP     highest CPU address decoded as program ROM
//   TIMEOUT     cycles allowed in REQ before a forced release (1..255)
//
// Ports:
//   i_CLK       system clock
//   i_RST       synchronous active-high reset
//   i_ADDR      CPU address bus
//   i_MREQ_n    CPU memory request
//   i_RD_n      CPU read strobe
//   i_RFSH_n    CPU refresh indicator
//   o_WAIT_n    wait line to the CPU
//   o_DO        raw ROM byte to the data mux/decrypter
//   o_ROM_RQ    memory-port request (level)
//   o_ROM_ADDR  memory-port byte address
//   i_ROM_ACK   memory-port acknowledge (1-cycle pulse)
//   i_ROM_DATA  memory-port data, valid with i_ROM_ACK
//   o_TIMEOUT   sticky flag: a fetch timed out
// -----------------------------------------------------------------------------
module suprloco_rom_fetch #(
    parameter logic [15:0] ROM_TOP = 16'hBFFF,
    parameter int          TIMEOUT = 255
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [15:0] i_ADDR,
    input  logic        i_MREQ_n,
    input  logic        i_RD_n,
    input  logic        i_RFSH_n,
    output logic        o_WAIT_n,
    output logic [7:0]  o_DO,
    output logic        o_ROM_RQ,
    output logic [15:0] o_ROM_ADDR,
    input  logic        i_ROM_ACK,
    input  logic [7:0]  i_ROM_DATA,
    output logic        o_TIMEOUT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // The counter counts completed REQ cycles; release happens on the edge
    // where it would reach TIMEOUT, i.e. after exactly TIMEOUT cycles in REQ.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        wait_n_q, wait_n_d;
    logic        rq_q, rq_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic [7:0]  do_q, do_d;
    logic        timeout_q, timeout_d;
    logic        valid_q, valid_d;
    logic [15:0] tag_q, tag_d;
    logic [7:0]  cnt_q, cnt_d;

    logic rd_cyc;
    logic hit;

    // Only genuine opcode/data reads of program ROM start a fetch; writes,
    // refresh, IO and the upper address space pass straight through.
    assign rd_cyc = ~i_MREQ_n & ~i_RD_n & i_RFSH_n & (i_ADDR <= ROM_TOP);
    assign hit    = valid_q & (tag_q == i_ADDR);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned, which would infer a latch.
        state_d    = state_q;
        wait_n_d   = wait_n_q;
        rq_d       = rq_q;
        rom_addr_d = rom_addr_q;
        do_d       = do_q;
        timeout_d  = timeout_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (rd_cyc) begin
                    if (hit) begin
                        // o_DO still holds the cached byte; no wait needed.
                        state_d = HOLD;
                    end else begin
                        state_d    = REQ;
                        wait_n_d   = 1'b0;
                        rq_d       = 1'b1;
                        rom_addr_d = i_ADDR;
                        cnt_d      = 8'd0;
                    end
                end
            end

            REQ: begin
                // Ack is checked first so it wins over a same-cycle timeout.
                if (i_ROM_ACK && rq_q) begin
                    do_d     = i_ROM_DATA;
                    tag_d    = rom_addr_q;
                    valid_d  = 1'b1;
                    rq_d     = 1'b0;
                    wait_n_d = 1'b1;
                    state_d  = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    do_d      = 8'hFF;
                    valid_d   = 1'b0;
                    rq_d      = 1'b0;
                    wait_n_d  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            HOLD: begin
                // Wait for the bus cycle to end so one CPU cycle never
                // triggers a second fetch.
                if (i_MREQ_n) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q    <= IDLE;
            wait_n_q   <= 1'b1;
            rq_q       <= 1'b0;
            rom_addr_q <= 16'h0000;
            do_q       <= 8'hFF;
            timeout_q  <= 1'b0;
            valid_q    <= 1'b0;
            tag_q      <= 16'h0000;
            cnt_q      <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values and the update order inside the block is moot.
            state_q    <= state_d;
            wait_n_q   <= wait_n_d;
            rq_q       <= rq_d;
            rom_addr_q <= rom_addr_d;
            do_q       <= do_d;
            timeout_q  <= timeout_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_WAIT_n   = wait_n_q;
    assign o_ROM_RQ   = rq_q;
    assign o_ROM_ADDR = rom_addr_q;
    assign o_DO       = do_q;
    assign o_TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_suprloco_rom_fetch.sv
// -----------------------------------------------------------------------------
// tb_suprloco_rom_fetch
//
// Self-checking bench for suprloco_rom_fetch. The bench plays both the CPU and
// the memory port. A transaction-level model (cache entry, last byte, sticky
// timeout flag, request count) predicts the outcome of every bus cycle.
// -----------------------------------------------------------------------------
module tb_suprloco_rom_fetch;

    localparam logic [15:0] TOP  = 16'hBFFF;
    localparam int          T    = 8;
    localparam int          NEVER = 1000;

    logic        i_CLK;
    logic        i_RST;
    logic [15:0] i_ADDR;
    logic        i_MREQ_n;
    logic        i_RD_n;
    logic        i_RFSH_n;
    logic        o_WAIT_n;
    logic [7:0]  o_DO;
    logic        o_ROM_RQ;
    logic [15:0] o_ROM_ADDR;
    logic        i_ROM_ACK;
    logic [7:0]  i_ROM_DATA;
    logic        o_TIMEOUT;

    suprloco_rom_fetch #(
        .ROM_TOP (TOP),
        .TIMEOUT (T)
    ) dut (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_ADDR     (i_ADDR),
        .i_MREQ_n   (i_MREQ_n),
        .i_RD_n     (i_RD_n),
        .i_RFSH_n   (i_RFSH_n),
        .o_WAIT_n   (o_WAIT_n),
        .o_DO       (o_DO),
        .o_ROM_RQ   (o_ROM_RQ),
        .o_ROM_ADDR (o_ROM_ADDR),
        .i_ROM_ACK  (i_ROM_ACK),
        .i_ROM_DATA (i_ROM_DATA),
        .o_TIMEOUT  (o_TIMEOUT)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    bit          m_valid;
    logic [15:0] m_tag;
    logic [7:0]  m_do;
    bit          m_to;
    int          m_req = 0;

    // Count rising edges of the request line, sampled mid-cycle.
    int   rq_rises = 0;
    logic rq_prev  = 1'b0;
    always @(negedge i_CLK) begin
        if (o_ROM_RQ === 1'b1 && rq_prev !== 1'b1) rq_rises <= rq_rises + 1;
        rq_prev <= o_ROM_RQ;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic bus_idle();
        i_MREQ_n  = 1'b1;
        i_RD_n    = 1'b1;
        i_RFSH_n  = 1'b1;
        i_ROM_ACK = 1'b0;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_tag   = 16'h0000;
        m_do    = 8'hFF;
        m_to    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wait"}, o_WAIT_n, 1);
        check({tag, "_rq"}, o_ROM_RQ, 0);
        check({tag, "_addr"}, o_ROM_ADDR, 0);
        check({tag, "_do"}, o_DO, 8'hFF);
        check({tag, "_to"}, o_TIMEOUT, 0);
    endtask

    task automatic do_reset();
        bus_idle();
        i_RST = 1'b1;
        tick();
        i_RST = 1'b0;
        model_reset();
        check_reset_values("rst");
    endtask

    // One CPU read bus cycle. ack_n: the memory acks during the ack_n-th cycle
    // after the request appears (NEVER = no ack at all).
    task automatic cpu_read(input logic [15:0] a, input int ack_n, input logic [7:0] d);
        bit hit;
        int k;
        int exp_low;
        hit = m_valid && (m_tag == a);
        i_ADDR   = a;
        i_MREQ_n = 1'b0;
        i_RD_n   = 1'b0;
        i_RFSH_n = 1'b1;
        tick();
        if (hit) begin
            check("hit_wait", o_WAIT_n, 1);
            check("hit_rq", o_ROM_RQ, 0);
            check("hit_do", o_DO, m_do);
            tick();
            tick();
            check("hit_hold_rq", o_ROM_RQ, 0);
            check("hit_hold_wait", o_WAIT_n, 1);
        end else begin
            m_req++;
            check("miss_wait", o_WAIT_n, 0);
            check("miss_rq", o_ROM_RQ, 1);
            check("miss_addr", o_ROM_ADDR, a);
            k = 0;
            while (o_WAIT_n === 1'b0 && k < 400) begin
                k++;
                i_ROM_ACK  = (k == ack_n);
                i_ROM_DATA = (k == ack_n) ? d : 8'($urandom);
                tick();
                i_ROM_ACK = 1'b0;
                if (o_WAIT_n === 1'b0) begin
                    check("req_rq_stable", o_ROM_RQ, 1);
                    check("req_addr_stable", o_ROM_ADDR, a);
                end
            end
            exp_low = (ack_n <= T) ? ack_n : T;
            check("wait_cycles", k, exp_low);
            if (ack_n <= T) begin
                m_valid = 1'b1;
                m_tag   = a;
                m_do    = d;
            end else begin
                m_valid = 1'b0;
                m_do    = 8'hFF;
                m_to    = 1'b1;
            end
            check("fetch_do", o_DO, m_do);
            check("fetch_rq_off", o_ROM_RQ, 0);
            check("fetch_to", o_TIMEOUT, m_to);
            // A stray ack while holding must not disturb anything.
            i_ROM_ACK  = 1'b1;
            i_ROM_DATA = ~m_do;
            tick();
            i_ROM_ACK = 1'b0;
            check("hold_ack_do", o_DO, m_do);
            check("hold_ack_wait", o_WAIT_n, 1);
        end
        check("req_count", rq_rises, m_req);
        bus_idle();
        tick();
    endtask

    // Bus cycles that must never start a fetch: 0 read above ROM_TOP,
    // 1 write, 2 refresh, 3 IO read.
    task automatic other_cycle(input int kind, input logic [15:0] a);
        i_ADDR   = a;
        i_MREQ_n = (kind == 3);
        i_RD_n   = (kind == 1);
        i_RFSH_n = (kind != 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pass_rq", o_ROM_RQ, 0);
            check("pass_wait", o_WAIT_n, 1);
        end
        check("pass_do", o_DO, m_do);
        check("pass_req_count", rq_rises, m_req);
        bus_idle();
        tick();
    endtask

    initial begin
        i_RST      = 1'b1;
        i_ADDR     = 16'h0000;
        i_ROM_DATA = 8'h00;
        bus_idle();
        model_reset();
        tick();

        do_reset();

        // Basic miss, then hit of the same address, then neighbour miss.
        cpu_read(16'h0123, 5, 8'h5A);
        cpu_read(16'h0123, 3, 8'h77);
        cpu_read(16'h0124, 2, 8'h3C);
        // Full 16-bit compare: only the top bit differs.
        cpu_read(16'h8124, 1, 8'hC3);
        cpu_read(16'h0124, 4, 8'h42);

        // Cycles that must pass through untouched.
        other_cycle(0, 16'hC000);
        other_cycle(1, 16'h0010);
        other_cycle(2, 16'h0010);
        other_cycle(3, 16'h0124);

        // Boundary: top of ROM qualifies; ack on the last allowed cycle wins.
        cpu_read(16'hBFFF, T, 8'h99);
        check("ack_at_limit_no_to", o_TIMEOUT, 0);
        // Timeout, then re-read misses again; the flag stays set.
        cpu_read(16'h2000, NEVER, 8'h00);
        cpu_read(16'h2000, 1, 8'h11);
        cpu_read(16'h3000, T + 1, 8'h22);

        // Reset in the middle of a request, then a late ack.
        do_reset();
        i_ADDR   = 16'h0456;
        i_MREQ_n = 1'b0;
        i_RD_n   = 1'b0;
        tick();
        m_req++;
        check("pre_rst_rq", o_ROM_RQ, 1);
        tick();
        tick();
        bus_idle();
        i_RST = 1'b1;
        tick();
        i_RST = 1'b0;
        model_reset();
        check_reset_values("rst_req");
        i_ROM_ACK  = 1'b1;
        i_ROM_DATA = 8'hA7;
        tick();
        i_ROM_ACK = 1'b0;
        check("late_ack_do", o_DO, 8'hFF);
        check("late_ack_rq", o_ROM_RQ, 0);
        check("late_ack_wait", o_WAIT_n, 1);
        tick();
        cpu_read(16'h0456, 3, 8'h6B);

        // Randomized traffic over a small address pool so hits are common.
        for (int it = 0; it < 200; it++) begin
            int          kind;
            int          n;
            logic [15:0] a;
            logic [15:0] pool [6];
            pool[0] = 16'h0000;
            pool[1] = 16'h0001;
            pool[2] = 16'h4001;
            pool[3] = 16'hBFFF;
            pool[4] = 16'h8000;
            pool[5] = 16'h0123;
            kind = $urandom_range(0, 9);
            a    = pool[$urandom_range(0, 5)];
            if (kind <= 6) begin
                n = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(1, T + 3);
                cpu_read(a, n, 8'($urandom));
            end else if (kind == 7) begin
                other_cycle(0, 16'($urandom_range(32'hC000, 32'hFFFF)));
            end else begin
                other_cycle($urandom_range(1, 3), a);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
